p405s_timer_wd_fit_gen: RTL and testbench



---
 rtl/p405s_timer_wd_fit_gen_pkg.sv | 26 ++
 rtl/p405s_timer_tap_edge.sv | 27 ++
 rtl/p405s_timer_wd_fit_gen.sv | 103 ++++++++++
 tb/tb_p405s_timer_wd_fit_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/p405s_timer_wd_fit_gen_pkg.sv
// rtl/p405s_timer_wd_fit_gen_pkg.sv - shared timer constants, watchdog state encoding, log2 helper
package p405s_timer_wd_fit_gen_pkg;

    localparam logic [1:0] WRS_NONE = 2'b00;
    localparam logic [1:0] WRS_CORE = 2'b01;
    localparam logic [1:0] WRS_CHIP = 2'b10;
    localparam logic [1:0] WRS_SYS  = 2'b11;

    // Encoding is {ENW, WIS} so the state bits drive the status outputs directly
    typedef enum logic [1:0] {
        WD_IDLE     = 2'b00,
        WD_WIS_ONLY = 2'b01,
        WD_ENW      = 2'b10,
        WD_INTR     = 2'b11
    } wd_state_t;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/p405s_timer_tap_edge.sv
// rtl/p405s_timer_tap_edge.sv - time-base tap mux with rising-edge event detect
module p405s_timer_tap_edge #(
    parameter int SELW = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [(1<<SELW)-1:0]   taps,
    input  logic [SELW-1:0]        sel,
    output logic                   tap_event
);

    logic selected;
    logic dly;

    assign selected  = taps[sel];
    // A select change onto a high tap fires too; the delay flop only tracks the muxed value
    assign tap_event = selected & ~dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly <= 1'b0;
        end else begin
            dly <= selected;
        end
    end

endmodule

// File: rtl/p405s_timer_wd_fit_gen.sv
// rtl/p405s_timer_wd_fit_gen.sv - watchdog FSM, held wd resets and sticky FIT status
module p405s_timer_wd_fit_gen
    import p405s_timer_wd_fit_gen_pkg::*;
#(
    parameter int NTAP = 4,
    parameter int SELW = log2(NTAP),
    parameter int NFIT = 2
) (
    input  logic                 timerClk,
    input  logic                 timerReset,
    input  logic [NTAP-1:0]      wdTaps,
    input  logic [SELW-1:0]      wdTapSel,
    input  logic [NFIT*NTAP-1:0] fitTaps,
    input  logic [NFIT*SELW-1:0] fitTapSel,
    input  logic [NFIT-1:0]      fitEn,
    input  logic [1:0]           wdRstType,
    input  logic                 swClrEnw,
    input  logic                 swClrWis,
    input  logic [NFIT-1:0]      swClrFit,
    input  logic                 timResetCore,
    output logic                 wdEnw,
    output logic                 wdWis,
    output logic                 wdIntrp,
    output logic [1:0]           wdRstRecord,
    output logic [NFIT-1:0]      fitStatus,
    output logic                 TIM_wdCoreRst,
    output logic                 TIM_wdChipRst,
    output logic                 TIM_wdSysRst
);

    wd_state_t       state;
    logic            hold;
    logic            wd_event;
    logic [NFIT-1:0] fit_event;

    p405s_timer_tap_edge #(.SELW(SELW)) u_wd_edge (
        .clk       (timerClk),
        .rst       (timerReset),
        .taps      (wdTaps),
        .sel       (wdTapSel),
        .tap_event (wd_event)
    );

    for (genvar c = 0; c < NFIT; c++) begin : g_fit
        p405s_timer_tap_edge #(.SELW(SELW)) u_fit_edge (
            .clk       (timerClk),
            .rst       (timerReset),
            .taps      (fitTaps[c*NTAP +: NTAP]),
            .sel       (fitTapSel[c*SELW +: SELW]),
            .tap_event (fit_event[c])
        );
    end

    assign wdEnw   = state[1];
    assign wdWis   = state[0];
    assign wdIntrp = state[0];

    // During a held reset everything except the core-reset handshake is frozen
    always_ff @(posedge timerClk or posedge timerReset) begin
        if (timerReset) begin
            state         <= WD_IDLE;
            hold          <= 1'b0;
            wdRstRecord   <= WRS_NONE;
            TIM_wdCoreRst <= 1'b0;
            TIM_wdChipRst <= 1'b0;
            TIM_wdSysRst  <= 1'b0;
        end else if (hold) begin
            if (timResetCore) begin
                hold          <= 1'b0;
                state         <= WD_IDLE;
                TIM_wdCoreRst <= 1'b0;
                TIM_wdChipRst <= 1'b0;
                TIM_wdSysRst  <= 1'b0;
            end
        end else if (wd_event) begin
            case (state)
                WD_IDLE:                state <= WD_ENW;
                WD_ENW, WD_WIS_ONLY:    state <= WD_INTR;
                WD_INTR: begin
                    if (wdRstType != WRS_NONE) begin
                        hold          <= 1'b1;
                        wdRstRecord   <= wdRstType;
                        TIM_wdCoreRst <= (wdRstType == WRS_CORE);
                        TIM_wdChipRst <= (wdRstType == WRS_CHIP);
                        TIM_wdSysRst  <= (wdRstType == WRS_SYS);
                    end
                end
                default:                state <= WD_IDLE;
            endcase
        end else begin
            state <= wd_state_t'({state[1] & ~swClrEnw, state[0] & ~swClrWis});
        end
    end

    always_ff @(posedge timerClk or posedge timerReset) begin
        if (timerReset) begin
            fitStatus <= '0;
        end else begin
            fitStatus <= (fitStatus & ~swClrFit) | (fit_event & fitEn);
        end
    end

endmodule

// File: tb/tb_p405s_timer_wd_fit_gen.sv
// tb/tb_p405s_timer_wd_fit_gen.sv - directed self-checking bench for the wd/FIT event engine
module tb_p405s_timer_wd_fit_gen;

    logic       timerClk;
    logic       timerReset;
    logic [3:0] wdTaps;
    logic [1:0] wdTapSel;
    logic [7:0] fitTaps;
    logic [3:0] fitTapSel;
    logic [1:0] fitEn;
    logic [1:0] wdRstType;
    logic       swClrEnw;
    logic       swClrWis;
    logic [1:0] swClrFit;
    logic       timResetCore;
    logic       wdEnw;
    logic       wdWis;
    logic       wdIntrp;
    logic [1:0] wdRstRecord;
    logic [1:0] fitStatus;
    logic       TIM_wdCoreRst;
    logic       TIM_wdChipRst;
    logic       TIM_wdSysRst;

    int n_checks = 0;
    int n_fail   = 0;
    int rst_seen = 0;

    p405s_timer_wd_fit_gen dut (
        .timerClk      (timerClk),
        .timerReset    (timerReset),
        .wdTaps        (wdTaps),
        .wdTapSel      (wdTapSel),
        .fitTaps       (fitTaps),
        .fitTapSel     (fitTapSel),
        .fitEn         (fitEn),
        .wdRstType     (wdRstType),
        .swClrEnw      (swClrEnw),
        .swClrWis      (swClrWis),
        .swClrFit      (swClrFit),
        .timResetCore  (timResetCore),
        .wdEnw         (wdEnw),
        .wdWis         (wdWis),
        .wdIntrp       (wdIntrp),
        .wdRstRecord   (wdRstRecord),
        .fitStatus     (fitStatus),
        .TIM_wdCoreRst (TIM_wdCoreRst),
        .TIM_wdChipRst (TIM_wdChipRst),
        .TIM_wdSysRst  (TIM_wdSysRst)
    );

    initial timerClk = 1'b0;
    always #5 timerClk = ~timerClk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge timerClk);
        #1;
        if (TIM_wdCoreRst | TIM_wdChipRst | TIM_wdSysRst) rst_seen++;
    endtask

    // One-cycle high pulse on watchdog tap 0; state observed right after the sampling edge
    task automatic wd_pulse();
        wdTaps = 4'b0001;
        tick();
    endtask

    task automatic wd_low();
        wdTaps = 4'b0000;
        tick();
    endtask

    function automatic logic [7:0] outs();
        return {wdEnw, wdWis, wdIntrp, TIM_wdCoreRst, TIM_wdChipRst, TIM_wdSysRst, fitStatus[0], fitStatus[1]};
    endfunction

    initial begin
        timerReset = 1'b1; wdTaps = '0; wdTapSel = '0; fitTaps = '0; fitTapSel = '0;
        fitEn = '0; wdRstType = 2'b10; swClrEnw = 0; swClrWis = 0; swClrFit = '0;
        timResetCore = 0;
        tick(); tick();
        check("reset_outs", outs(), 8'h00);
        check("reset_wrs", {6'b0, wdRstRecord}, 8'h00);
        timerReset = 1'b0;
        tick();

        // Async reset mid-cycle after reaching ENW
        wd_pulse(); wd_low();
        check("pre_rst_enw", {7'b0, wdEnw}, 8'h01);
        #2 timerReset = 1'b1;
        #1 check("async_rst_outs", outs(), 8'h00);
        tick();
        timerReset = 1'b0;
        tick();

        // Three pulses, chip reset
        wd_pulse();
        check("p1_enw_wis", {6'b0, wdEnw, wdWis}, 8'h02);
        wd_low();
        wd_pulse();
        check("p2_enw_wis_int", {5'b0, wdEnw, wdWis, wdIntrp}, 8'h07);
        wd_low();
        wd_pulse();
        check("p3_rsts", {5'b0, TIM_wdCoreRst, TIM_wdChipRst, TIM_wdSysRst}, 8'h02);
        check("p3_wrs", {6'b0, wdRstRecord}, 8'h02);
        wd_low();
        for (int i = 0; i < 20; i++) begin
            wdTaps = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            swClrEnw = 1; swClrWis = 1; wdRstType = 2'b11;
            tick();
        end
        swClrEnw = 0; swClrWis = 0; wdRstType = 2'b10; wdTaps = '0;
        check("hold_chip", {5'b0, TIM_wdCoreRst, TIM_wdChipRst, TIM_wdSysRst}, 8'h02);
        check("hold_state", {6'b0, wdEnw, wdWis}, 8'h03);
        timResetCore = 1;
        tick();
        timResetCore = 0;
        check("release_outs", outs(), 8'h00);
        check("release_wrs", {6'b0, wdRstRecord}, 8'h02);

        // No-reset type: stays in INTR, 01 state reachable and advances to 11
        wdRstType = 2'b00;
        rst_seen = 0;
        for (int i = 0; i < 4; i++) begin
            wd_pulse(); wd_low();
        end
        check("none_state", {6'b0, wdEnw, wdWis}, 8'h03);
        swClrEnw = 1; tick(); swClrEnw = 0;
        check("clr_enw_01", {6'b0, wdEnw, wdWis}, 8'h01);
        wd_pulse(); wd_low();
        check("state01_adv", {6'b0, wdEnw, wdWis}, 8'h03);
        check("none_no_rst", rst_seen[7:0], 8'h00);
        swClrEnw = 1; swClrWis = 1; tick(); swClrEnw = 0; swClrWis = 0;
        check("clr_both", {6'b0, wdEnw, wdWis}, 8'h00);

        // Held tap: only one advance; select change onto a high tap: one event
        wdTaps = 4'b0001;
        for (int i = 0; i < 50; i++) tick();
        check("held_one_adv", {6'b0, wdEnw, wdWis}, 8'h02);
        wdTaps = 4'b0100;
        tick();
        check("sel_low_noadv", {6'b0, wdEnw, wdWis}, 8'h02);
        wdTapSel = 2'd2;
        tick();
        check("sel_change_evt", {6'b0, wdEnw, wdWis}, 8'h03);
        wdTaps = '0; wdTapSel = '0;
        tick();

        // INTR + swClrWis + event with core type: hardware wins
        wdRstType = 2'b01; swClrWis = 1; wdTaps = 4'b0001;
        tick();
        swClrWis = 0; wdTaps = '0;
        check("hw_wins_core", {5'b0, TIM_wdCoreRst, TIM_wdChipRst, TIM_wdSysRst}, 8'h04);
        check("hw_wins_wrs", {6'b0, wdRstRecord}, 8'h01);
        timResetCore = 1; tick(); timResetCore = 0;
        check("core_release", outs(), 8'h00);

        // FIT channels: ch0 tap1 (bit1), ch1 tap3 (bit7)
        fitTapSel = {2'b11, 2'b01}; fitEn = 2'b11;
        fitTaps = 8'h02; tick();
        check("fit_ch0", {6'b0, fitStatus}, 8'h01);
        fitTaps = 8'h00; tick();
        fitTaps = 8'h80; tick();
        check("fit_ch1", {6'b0, fitStatus}, 8'h03);
        fitTaps = 8'h00; swClrFit = 2'b11; tick(); swClrFit = 2'b00;
        check("fit_clr", {6'b0, fitStatus}, 8'h00);
        fitTaps = 8'h02; swClrFit = 2'b01; tick(); swClrFit = 2'b00;
        check("fit_set_wins", {6'b0, fitStatus}, 8'h01);
        fitTaps = 8'h00; tick();
        fitEn = 2'b01; fitTaps = 8'h80; tick();
        check("fit_disabled", {6'b0, fitStatus}, 8'h01);
        fitTaps = 8'h00; tick();

        // Record cleared only by timerReset
        check("wrs_kept", {6'b0, wdRstRecord}, 8'h01);
        #2 timerReset = 1'b1;
        #1 check("final_rst_wrs", {6'b0, wdRstRecord}, 8'h00);
        check("final_rst_outs", outs(), 8'h00);
        tick();
        timerReset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
